sprite_fetch_sched: RTL and testbench

- Per-pixel sprite scheduler that shares the single sprite_mux lookup path (object_id/addr in, 24-bit sprite_pixel out) among NUM_OBJ on-screen objects.
- For each requested screen pixel it scans an object table in priority order (index 0 highest) and fetches the sprite texel of each object whose 32x32 box covers the pixel.
- It returns the first non-transparent colour, or BG_COLOR if no object supplies one.
- Sits between the VGA pixel pipeline (request side) and sprite_mux/sprite ROMs (fetch side).

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_hit_calc.sv | 37 +++
 rtl/sprite_fetch_sched.sv | 174 +++++++++++++++++
 tb/tb_sprite_fetch_sched.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and widths for the sprite fetch scheduler and its hit calculator.
package sprite_pkg;

  localparam int SPR_SIZE = 32;
  localparam int SPR_LOG2 = 5;
  localparam int OBJ_ID_W = 5;
  localparam int COORD_W  = 10;
  localparam int COLOR_W  = 24;

  typedef struct packed {
    logic               active;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               hflip;
  } obj_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational box test of one object entry against a pixel, producing texel offsets.
// Mirrors dx when SPRITE_HFLIP_EN is defined and the entry is flagged as flipped.
module sprite_hit_calc
  import sprite_pkg::*;
(
  input  obj_entry_t          entry,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  output logic                hit,
  output logic [SPR_LOG2-1:0] dx,
  output logic [SPR_LOG2-1:0] dy
);

  logic [COORD_W:0] diff_x;
  logic [COORD_W:0] diff_y;

  // 11-bit differences: a negative result (sign bit set) is a miss, so boxes never wrap past 1023.
  always_comb begin
    diff_x = {1'b0, pix_x} - {1'b0, entry.x};
    diff_y = {1'b0, pix_y} - {1'b0, entry.y};
    hit    = entry.active
           && (diff_x[COORD_W:SPR_LOG2] == '0)
           && (diff_y[COORD_W:SPR_LOG2] == '0);
    dy     = diff_y[SPR_LOG2-1:0];
`ifdef SPRITE_HFLIP_EN
    dx     = entry.hflip ? ~diff_x[SPR_LOG2-1:0] : diff_x[SPR_LOG2-1:0];
`else
    dx     = diff_x[SPR_LOG2-1:0];
`endif
  end

`ifndef SPRITE_HFLIP_EN
  logic unused_hflip;
  assign unused_hflip = entry.hflip;
`endif

endmodule

// File: rtl/sprite_fetch_sched.sv
// Per-pixel sprite scheduler: scans the object table in priority order and fetches texels
// through the shared sprite_mux path. Optional per-entry mirroring via SPRITE_HFLIP_EN.
module sprite_fetch_sched
  import sprite_pkg::*;
#(
  parameter int                 NUM_OBJ     = 8,
  parameter int                 ROM_LAT     = 1,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 24'hFF00FF,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 24'h000000
) (
  input  logic                clk50,
  input  logic                reset_n,
  input  logic                obj_we,
  input  logic [OBJ_ID_W-1:0] obj_idx,
  input  logic [COORD_W-1:0]  obj_x,
  input  logic [COORD_W-1:0]  obj_y,
  input  logic                obj_active,
  input  logic                obj_hflip,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COORD_W-1:0]  req_x,
  input  logic [COORD_W-1:0]  req_y,
  output logic [OBJ_ID_W-1:0] object_id,
  output logic [9:0]          addr,
  input  logic [COLOR_W-1:0]  sprite_pixel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [COLOR_W-1:0]  rsp_pixel,
  output logic                busy
);

  // Index can reach NUM_OBJ: one terminal scan step follows a miss on the last entry.
  localparam int IDX_W = $clog2(NUM_OBJ + 1);
  localparam int CNT_W = 3;

  obj_entry_t          table_q [NUM_OBJ];
  obj_entry_t          wr_entry;
  obj_entry_t          cur_entry;
  sched_state_t        state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COORD_W-1:0]  req_x_q, req_x_d;
  logic [COORD_W-1:0]  req_y_q, req_y_d;
  logic [OBJ_ID_W-1:0] object_id_q, object_id_d;
  logic [9:0]          addr_q, addr_d;
  logic [COLOR_W-1:0]  rsp_pixel_q, rsp_pixel_d;
  logic                hit;
  logic [SPR_LOG2-1:0] hit_dx, hit_dy;

  always_comb begin
    wr_entry.active = obj_active;
    wr_entry.x      = obj_x;
    wr_entry.y      = obj_y;
`ifdef SPRITE_HFLIP_EN
    wr_entry.hflip  = obj_hflip;
`else
    wr_entry.hflip  = 1'b0;
`endif
  end

`ifndef SPRITE_HFLIP_EN
  logic unused_obj_hflip;
  assign unused_obj_hflip = obj_hflip;
`endif

  // Out-of-range obj_idx matches no entry, so such writes fall away.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OBJ; i++) table_q[i] <= '0;
    end else if (obj_we) begin
      for (int i = 0; i < NUM_OBJ; i++)
        if (obj_idx == OBJ_ID_W'(i)) table_q[i] <= wr_entry;
    end
  end

  always_comb begin
    cur_entry = '0;
    for (int i = 0; i < NUM_OBJ; i++)
      if (idx_q == IDX_W'(i)) cur_entry = table_q[i];
  end

  sprite_hit_calc u_hit (
    .entry (cur_entry),
    .pix_x (req_x_q),
    .pix_y (req_y_q),
    .hit   (hit),
    .dx    (hit_dx),
    .dy    (hit_dy)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    req_x_d     = req_x_q;
    req_y_d     = req_y_q;
    object_id_d = object_id_q;
    addr_d      = addr_q;
    rsp_pixel_d = rsp_pixel_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_x_d = req_x;
          req_y_d = req_y;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_OBJ)) begin
          rsp_pixel_d = BG_COLOR;
          state_d     = DONE;
        end else if (hit) begin
          object_id_d = OBJ_ID_W'(idx_q);
          addr_d      = {hit_dy, hit_dx};
          cnt_d       = CNT_W'(ROM_LAT);
          state_d     = WAIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (sprite_pixel != TRANSPARENT) begin
            rsp_pixel_d = sprite_pixel;
            state_d     = DONE;
          end else if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
            rsp_pixel_d = BG_COLOR;
            state_d     = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      object_id_q <= '0;
      addr_q      <= '0;
      rsp_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      object_id_q <= object_id_d;
      addr_q      <= addr_d;
      rsp_pixel_q <= rsp_pixel_d;
    end
  end

  assign req_ready = (state_q == IDLE) && reset_n;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign object_id = object_id_q;
  assign addr      = addr_q;
  assign rsp_pixel = rsp_pixel_q;

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// Randomized and directed bench for sprite_fetch_sched against a scan-order reference model.
module tb_sprite_fetch_sched;

  localparam int          NUM_OBJ = 8;
  localparam int          ROM_LAT = 1;
  localparam logic [23:0] TRANSP  = 24'hFF00FF;
  localparam logic [23:0] BG      = 24'h000000;
`ifdef SPRITE_HFLIP_EN
  localparam bit HF_EN = 1'b1;
`else
  localparam bit HF_EN = 1'b0;
`endif

  logic        clk50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        obj_we = 1'b0;
  logic [4:0]  obj_idx = '0;
  logic [9:0]  obj_x = '0, obj_y = '0;
  logic        obj_active = 1'b0, obj_hflip = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [9:0]  req_x = '0, req_y = '0;
  logic [4:0]  object_id;
  logic [9:0]  addr;
  logic [23:0] sprite_pixel;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [23:0] rsp_pixel;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference state: object table copy, texel memory, last fetched id/addr.
  logic        tb_act [NUM_OBJ];
  logic [9:0]  tb_x   [NUM_OBJ];
  logic [9:0]  tb_y   [NUM_OBJ];
  logic        tb_hf  [NUM_OBJ];
  logic [23:0] rom    [NUM_OBJ][1024];
  logic [4:0]  last_id;
  logic [9:0]  last_addr;

  always #10 clk50 = ~clk50;

  always_comb begin
    sprite_pixel = rom[object_id[2:0]][addr];
  end

  sprite_fetch_sched #(
    .NUM_OBJ(NUM_OBJ), .ROM_LAT(ROM_LAT), .TRANSPARENT(TRANSP), .BG_COLOR(BG)
  ) dut (
    .clk50(clk50), .reset_n(reset_n), .obj_we(obj_we), .obj_idx(obj_idx),
    .obj_x(obj_x), .obj_y(obj_y), .obj_active(obj_active), .obj_hflip(obj_hflip),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .object_id(object_id), .addr(addr), .sprite_pixel(sprite_pixel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_pixel(rsp_pixel), .busy(busy)
  );

  task automatic model_clear();
    for (int i = 0; i < NUM_OBJ; i++) begin
      tb_act[i] = 1'b0; tb_x[i] = '0; tb_y[i] = '0; tb_hf[i] = 1'b0;
    end
    last_id   = '0;
    last_addr = '0;
  endtask

  task automatic write_obj(input int idx, input int x, input int y, input bit act, input bit hf);
    obj_idx = 5'(idx); obj_x = 10'(x); obj_y = 10'(y);
    obj_active = act; obj_hflip = hf; obj_we = 1'b1;
    @(posedge clk50); #1;
    obj_we = 1'b0;
    if (idx < NUM_OBJ) begin
      tb_act[idx] = act; tb_x[idx] = 10'(x); tb_y[idx] = 10'(y); tb_hf[idx] = hf;
    end
  endtask

  // One full request/response transaction; expected trace comes from walking the table in priority order.
  task automatic do_req(input int rx, input int ry, input int hold, input string tag);
    logic [4:0]  eid [$];
    logic [9:0]  ead [$];
    logic [4:0]  cid;
    logic [9:0]  cad;
    logic [23:0] ecol;
    bit          found, last_hit, got;
    int          dxi, dyi, cyc;
    cid = last_id; cad = last_addr; ecol = BG; found = 0; last_hit = 0;
    for (int i = 0; i < NUM_OBJ && !found; i++) begin
      dxi = rx - int'(tb_x[i]);
      dyi = ry - int'(tb_y[i]);
      if (tb_act[i] && dxi >= 0 && dxi < 32 && dyi >= 0 && dyi < 32) begin
        if (HF_EN && tb_hf[i]) dxi = 31 - dxi;
        cid = 5'(i);
        cad = 10'(dyi * 32 + dxi);
        for (int k = 0; k <= ROM_LAT; k++) begin
          eid.push_back(cid); ead.push_back(cad);
        end
        if (rom[i][cad] != TRANSP) begin
          ecol  = rom[i][cad];
          found = 1;
        end
        last_hit = (i == NUM_OBJ - 1);
      end else begin
        eid.push_back(cid); ead.push_back(cad);
        last_hit = 0;
      end
    end
    if (!found && !last_hit) begin
      eid.push_back(cid); ead.push_back(cad);
    end

    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL %s req_ready_idle got=%b want=1", tag, req_ready);
    end
    req_x = 10'(rx); req_y = 10'(ry); req_valid = 1'b1;
    @(posedge clk50); #1;
    req_valid = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(posedge clk50); #1;
      cyc++;
      if (cyc <= eid.size()) begin
        total++;
        if (object_id !== eid[cyc-1] || addr !== ead[cyc-1]) begin
          bad++;
          $display("FAIL %s trace cyc=%0d got id=%0d addr=%0d want id=%0d addr=%0d",
                   tag, cyc, object_id, addr, eid[cyc-1], ead[cyc-1]);
        end
      end
      if (rsp_valid === 1'b1) got = 1;
    end
    total++;
    if (!got || cyc != eid.size()) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", tag, cyc, eid.size());
    end
    total++;
    if (rsp_pixel !== ecol) begin
      bad++; $display("FAIL %s rsp_pixel got=%h want=%h", tag, rsp_pixel, ecol);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk50); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_pixel !== ecol || req_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s hold%0d got v=%b pix=%h rdy=%b busy=%b want v=1 pix=%h rdy=0 busy=1",
                 tag, h, rsp_valid, rsp_pixel, req_ready, busy, ecol);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk50); #1;
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s release got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
               tag, rsp_valid, req_ready, busy);
    end
    $display("txn %s req=(%0d,%0d) pix=%h lat=%0d", tag, rx, ry, rsp_pixel, cyc);
    last_id = cid; last_addr = cad;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk50);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || object_id !== 5'd0 || addr !== 10'd0 ||
        rsp_pixel !== 24'd0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got v=%b busy=%b id=%0d addr=%0d pix=%h rdy=%b want all 0",
               rsp_valid, busy, object_id, addr, rsp_pixel, req_ready);
    end
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release req_ready got=%b want=1", req_ready);
    end
    @(posedge clk50); #1;
  endtask

  task automatic test_empty();
    do_req(100, 50, 0, "empty");
  endtask

  task automatic test_single_hit();
    rom[0][324] = 24'h00FF00;
    write_obj(0, 96, 40, 1, 0);
    do_req(100, 50, 0, "single_hit");
  endtask

  task automatic test_transparent_chain();
    rom[0][324] = TRANSP;
    rom[3][170] = 24'h123456;
    write_obj(3, 90, 45, 1, 0);
    do_req(100, 50, 0, "chain");
  endtask

  task automatic test_hold();
    do_req(100, 50, 5, "hold");
  endtask

  task automatic test_idx_ignore();
    write_obj(0, 0, 0, 0, 0);
    write_obj(3, 0, 0, 0, 0);
    write_obj(8, 96, 40, 1, 0);
    write_obj(31, 96, 40, 1, 0);
    do_req(100, 50, 0, "idx_ignore");
  endtask

  task automatic test_no_wrap_and_reset();
    write_obj(1, 1000, 0, 1, 0);
    do_req(2, 0, 0, "no_wrap");
    do_req(1010, 5, 0, "edge_hit");
    rom[0][3] = 24'hABCDEF;
    write_obj(0, 0, 0, 1, 0);
    req_x = 10'd3; req_y = 10'd0; req_valid = 1'b1;
    @(posedge clk50); #1;
    req_valid = 1'b0;
    @(posedge clk50); #1;
    total++;
    if (busy !== 1'b1 || object_id !== 5'd0 || addr !== 10'd3) begin
      bad++; $display("FAIL midwait_pre got busy=%b id=%0d addr=%0d want 1 0 3", busy, object_id, addr);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midwait_reset got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
    model_clear();
    @(posedge clk50); #1;
    reset_n = 1'b1;
    @(posedge clk50); #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset got v=%b busy=%b rdy=%b want 0 0 1", rsp_valid, busy, req_ready);
    end
    do_req(3, 0, 0, "after_reset_empty");
  endtask

`ifdef SPRITE_HFLIP_EN
  task automatic test_hflip();
    rom[0][28] = 24'h0F0F0F;
    write_obj(0, 0, 0, 1, 1);
    do_req(3, 0, 0, "hflip");
  endtask
`endif

  task automatic test_random();
    int cx, cy, n, ox, oy;
    for (int o = 0; o < NUM_OBJ; o++)
      for (int a = 0; a < 1024; a++)
        rom[o][a] = ($urandom_range(0, 2) == 0) ? TRANSP : 24'($urandom);
    for (int t = 0; t < 30; t++) begin
      cx = $urandom_range(0, 1023);
      cy = $urandom_range(0, 1023);
      n  = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) begin
        ox = cx - $urandom_range(0, 40);
        oy = cy - $urandom_range(0, 40);
        if (ox < 0) ox = 0;
        if (oy < 0) oy = 0;
        write_obj($urandom_range(0, 9), ox, oy, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      end
      do_req(cx, cy, $urandom_range(0, 2), $sformatf("rand%0d", t));
    end
  endtask

  initial begin
    for (int o = 0; o < NUM_OBJ; o++)
      for (int a = 0; a < 1024; a++)
        rom[o][a] = 24'h5A5A5A;
    test_reset();
    test_empty();
    test_single_hit();
    test_transparent_chain();
    test_hold();
    test_idx_ignore();
    test_no_wrap_and_reset();
`ifdef SPRITE_HFLIP_EN
    test_hflip();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
